// File: rtl/if_id_queue.sv
// IF/ID stage with a DEPTH-entry FIFO between fetch and decode, so IF keeps running while ID stalls.
// Optional empty-queue bypass (1-cycle IF->ID latency) is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          if_pc,
  input  logic [INST_W-1:0]          if_inst,
  input  logic [EXC_W-1:0]           if_excepttype,
  input  logic                       if_isbubble,
  input  logic                       id_stall,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [EXC_W-1:0]           id_excepttype,
  output logic                       id_isbubble,
  output logic                       id_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + INST_W + EXC_W + 1;

  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic [EXC_W-1:0]  r_id_exc;
  logic              r_id_isbubble;
  logic              r_id_valid;

  logic              w_in_ready;
  logic              w_empty;
  logic              w_accept;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_wr_entry;
  logic [ENT_W-1:0]  w_head;

  // Full queue never accepts, even when ID pops in the same cycle.
  assign w_in_ready = !rst && (r_count < CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_accept   = in_valid && w_in_ready && !flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_bypass = w_accept && !id_stall && w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push     = w_accept && !w_bypass;
  assign w_pop      = !rst && !flush && !id_stall && !w_empty;
  assign w_wr_entry = {if_isbubble, if_excepttype, if_inst, if_pc};
  assign w_head     = r_mem[r_rd_ptr];

  // Storage has no reset so it maps onto plain RAM; validity lives in r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_pc       <= '0;
      r_id_inst     <= '0;
      r_id_exc      <= '0;
      r_id_isbubble <= 1'b0;
      r_id_valid    <= 1'b0;
    end else if (flush) begin
      r_id_pc       <= '0;
      r_id_inst     <= '0;
      r_id_exc      <= '0;
      r_id_isbubble <= 1'b1;
      r_id_valid    <= 1'b0;
    end else if (id_stall) begin
      r_id_pc       <= r_id_pc;
      r_id_inst     <= r_id_inst;
      r_id_exc      <= r_id_exc;
      r_id_isbubble <= r_id_isbubble;
      r_id_valid    <= r_id_valid;
    end else if (w_pop) begin
      {r_id_isbubble, r_id_exc, r_id_inst, r_id_pc} <= w_head;
      r_id_valid <= 1'b1;
    end else if (w_bypass) begin
      r_id_pc       <= if_pc;
      r_id_inst     <= if_inst;
      r_id_exc      <= if_excepttype;
      r_id_isbubble <= if_isbubble;
      r_id_valid    <= 1'b1;
    end else begin
      r_id_pc       <= '0;
      r_id_inst     <= '0;
      r_id_exc      <= '0;
      r_id_isbubble <= 1'b1;
      r_id_valid    <= 1'b0;
    end
  end

  assign in_ready      = w_in_ready;
  assign id_pc         = r_id_pc;
  assign id_inst       = r_id_inst;
  assign id_excepttype = r_id_exc;
  assign id_isbubble   = r_id_isbubble;
  assign id_valid      = r_id_valid;
  assign count         = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed table-driven bench for if_id_queue (DEPTH=4); expectations follow IF_ID_QUEUE_BYPASS_EN.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, if_isbubble, id_stall;
  logic [31:0] if_pc, if_inst, if_excepttype;
  logic [31:0] id_pc, id_inst, id_excepttype;
  logic        id_isbubble, id_valid;
  logic [2:0]  count;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .EXC_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_excepttype(if_excepttype), .if_isbubble(if_isbubble),
    .id_stall(id_stall), .id_pc(id_pc), .id_inst(id_inst), .id_excepttype(id_excepttype),
    .id_isbubble(id_isbubble), .id_valid(id_valid), .count(count)
  );

  typedef struct {
    string       name;
    logic        rst, flush, iv, isb, stall;
    logic [31:0] pc, exc;
    logic [31:0] epc, eexc;
    logic        eisb, evalid, erdy;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(string name, logic r, logic f, logic iv, logic [31:0] pc,
                              logic [31:0] exc, logic isb, logic st,
                              logic [31:0] epc, logic [31:0] eexc, logic eisb,
                              logic ev, logic [2:0] ecnt, logic erdy);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.exc = exc;
    v.isb = isb; v.stall = st; v.epc = epc; v.eexc = eexc; v.eisb = eisb;
    v.evalid = ev; v.ecnt = ecnt; v.erdy = erdy;
    vq.push_back(v);
  endfunction

  initial begin
    logic [31:0] exp_inst;
    int          lat;
    int          exp_lat;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; if_pc = '0; if_inst = '0;
    if_excepttype = '0; if_isbubble = 1'b0; id_stall = 1'b0;

    //   name        rst fl iv pc       exc     isb st  epc      eexc    eisb ev cnt rdy
    add("rst1",      1, 0, 1, 32'h10,  0,      0, 0,  0,       0,      0, 0, 0, 0);
    add("rst2",      1, 0, 1, 32'h10,  0,      0, 0,  0,       0,      0, 0, 0, 0);
    add("rst_rel",   0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
`ifdef IF_ID_QUEUE_BYPASS_EN
    add("str1",      0, 0, 1, 32'h100, 0,      0, 0,  32'h100, 0,      0, 1, 0, 1);
    add("str2",      0, 0, 1, 32'h104, 0,      0, 0,  32'h104, 0,      0, 1, 0, 1);
    add("str3",      0, 0, 1, 32'h108, 0,      0, 0,  32'h108, 0,      0, 1, 0, 1);
    add("str4",      0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("str5",      0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("exc1",      0, 0, 1, 32'h300, 32'h200,1, 0,  32'h300, 32'h200,1, 1, 0, 1);
    add("exc2",      0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("exc3",      0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("fill0",     0, 0, 1, 32'h200, 0,      0, 0,  32'h200, 0,      0, 1, 0, 1);
    add("fill0b",    0, 0, 0, 0,       0,      0, 1,  32'h200, 0,      0, 1, 0, 1);
`else
    add("str1",      0, 0, 1, 32'h100, 0,      0, 0,  0,       0,      1, 0, 1, 1);
    add("str2",      0, 0, 1, 32'h104, 0,      0, 0,  32'h100, 0,      0, 1, 1, 1);
    add("str3",      0, 0, 1, 32'h108, 0,      0, 0,  32'h104, 0,      0, 1, 1, 1);
    add("str4",      0, 0, 0, 0,       0,      0, 0,  32'h108, 0,      0, 1, 0, 1);
    add("str5",      0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("exc1",      0, 0, 1, 32'h300, 32'h200,1, 0,  0,       0,      1, 0, 1, 1);
    add("exc2",      0, 0, 0, 0,       0,      0, 0,  32'h300, 32'h200,1, 1, 0, 1);
    add("exc3",      0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("fill0",     0, 0, 1, 32'h200, 0,      0, 0,  0,       0,      1, 0, 1, 1);
    add("fill0b",    0, 0, 0, 0,       0,      0, 0,  32'h200, 0,      0, 1, 0, 1);
`endif
    add("fill1",     0, 0, 1, 32'h204, 0,      0, 1,  32'h200, 0,      0, 1, 1, 1);
    add("fill2",     0, 0, 1, 32'h208, 0,      0, 1,  32'h200, 0,      0, 1, 2, 1);
    add("fill3",     0, 0, 1, 32'h20C, 0,      0, 1,  32'h200, 0,      0, 1, 3, 1);
    add("fill4",     0, 0, 1, 32'h210, 0,      0, 1,  32'h200, 0,      0, 1, 4, 0);
    add("fill_ref",  0, 0, 1, 32'h214, 0,      0, 1,  32'h200, 0,      0, 1, 4, 0);
    add("full_pop",  0, 0, 1, 32'h214, 0,      0, 0,  32'h204, 0,      0, 1, 3, 1);
    add("reaccept",  0, 0, 1, 32'h214, 0,      0, 0,  32'h208, 0,      0, 1, 3, 1);
    add("drain1",    0, 0, 0, 0,       0,      0, 0,  32'h20C, 0,      0, 1, 2, 1);
    add("drain2",    0, 0, 0, 0,       0,      0, 0,  32'h210, 0,      0, 1, 1, 1);
    add("drain3",    0, 0, 0, 0,       0,      0, 0,  32'h214, 0,      0, 1, 0, 1);
    add("drain4",    0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("wrap1",     0, 0, 1, 32'h400, 0,      0, 1,  0,       0,      1, 0, 1, 1);
    add("wrap2",     0, 0, 1, 32'h404, 0,      0, 1,  0,       0,      1, 0, 2, 1);
    add("wrap3",     0, 0, 1, 32'h408, 0,      0, 0,  32'h400, 0,      0, 1, 2, 1);
    add("wrap4",     0, 0, 1, 32'h40C, 0,      0, 0,  32'h404, 0,      0, 1, 2, 1);
    add("wrap5",     0, 0, 1, 32'h410, 0,      0, 1,  32'h404, 0,      0, 1, 3, 1);
    add("wrap6",     0, 0, 0, 0,       0,      0, 0,  32'h408, 0,      0, 1, 2, 1);
    add("wrap7",     0, 0, 1, 32'h414, 0,      0, 0,  32'h40C, 0,      0, 1, 2, 1);
    add("wrap8",     0, 0, 0, 0,       0,      0, 0,  32'h410, 0,      0, 1, 1, 1);
    add("wrap9",     0, 0, 1, 32'h418, 0,      0, 1,  32'h410, 0,      0, 1, 2, 1);
    add("wrap10",    0, 0, 1, 32'h41C, 0,      0, 0,  32'h414, 0,      0, 1, 2, 1);
    add("wrap11",    0, 0, 0, 0,       0,      0, 0,  32'h418, 0,      0, 1, 1, 1);
    add("wrap12",    0, 0, 0, 0,       0,      0, 0,  32'h41C, 0,      0, 1, 0, 1);
    add("fl_q1",     0, 0, 1, 32'h500, 0,      0, 1,  32'h41C, 0,      0, 1, 1, 1);
    add("fl_q2",     0, 0, 1, 32'h504, 0,      0, 1,  32'h41C, 0,      0, 1, 2, 1);
    add("fl_q3",     0, 0, 1, 32'h508, 0,      0, 1,  32'h41C, 0,      0, 1, 3, 1);
    add("flush",     0, 1, 1, 32'h50C, 0,      0, 1,  0,       0,      1, 0, 0, 1);
    add("fl_after1", 0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("fl_after2", 0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);
    add("mid_q1",    0, 0, 1, 32'h600, 0,      0, 1,  0,       0,      1, 0, 1, 1);
    add("mid_q2",    0, 0, 1, 32'h604, 0,      0, 1,  0,       0,      1, 0, 2, 1);
    add("mid_rst",   1, 0, 1, 32'h608, 0,      0, 0,  0,       0,      0, 0, 0, 0);
    add("mid_rel",   0, 0, 0, 0,       0,      0, 0,  0,       0,      1, 0, 0, 1);

    foreach (vq[i]) begin
      rst = vq[i].rst; flush = vq[i].flush; in_valid = vq[i].iv; if_pc = vq[i].pc;
      if_inst = ~vq[i].pc; if_excepttype = vq[i].exc; if_isbubble = vq[i].isb;
      id_stall = vq[i].stall;
      @(posedge clk); #1;
      exp_inst = vq[i].evalid ? ~vq[i].epc : 32'h0;
      n_vec++;
      if (id_pc !== vq[i].epc || id_inst !== exp_inst || id_excepttype !== vq[i].eexc ||
          id_isbubble !== vq[i].eisb || id_valid !== vq[i].evalid ||
          count !== vq[i].ecnt || in_ready !== vq[i].erdy) begin
        n_miss++;
        $display("FAIL %s: got pc=%h inst=%h exc=%h isb=%b v=%b cnt=%0d rdy=%b want pc=%h inst=%h exc=%h isb=%b v=%b cnt=%0d rdy=%b",
                 vq[i].name, id_pc, id_inst, id_excepttype, id_isbubble, id_valid, count, in_ready,
                 vq[i].epc, exp_inst, vq[i].eexc, vq[i].eisb, vq[i].evalid, vq[i].ecnt, vq[i].erdy);
      end else begin
        $display("vec %0d %s: pc=%h v=%b cnt=%0d rdy=%b", i, vq[i].name, id_pc, id_valid, count, in_ready);
      end
    end

    // Measure IF->ID latency of a lone instruction offered to an idle, unstalled queue.
`ifdef IF_ID_QUEUE_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    rst = 1'b0; flush = 1'b0; id_stall = 1'b0; in_valid = 1'b1;
    if_pc = 32'h700; if_inst = ~32'h700; if_excepttype = '0; if_isbubble = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!id_valid && lat < 6);
    n_vec++;
    if (!id_valid || lat != exp_lat || id_pc !== 32'h700 || id_inst !== ~32'h700) begin
      n_miss++;
      $display("FAIL latency: got lat=%0d v=%b pc=%h want lat=%0d v=1 pc=00000700",
               lat, id_valid, id_pc, exp_lat);
    end else begin
      $display("latency: lat=%0d pc=%h", lat, id_pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor of the IF/ID pipeline register.
- Inserts a DEPTH-entry instruction queue between IF and ID, so fetch can keep running while ID is stalled.
- Presents one registered {pc, inst, excepttype, isbubble} slot to ID, with the same bubble and flush semantics as the single-register stage.
- Handshake: valid/ready toward IF, a single stall line from ID.

Parameters:
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- EXC_W, 32, exception-type vector width
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high (RstEnable)
- flush  in  1  discard all queued and presented instructions
- in_valid  in  1  IF presents an instruction this cycle
- in_ready  out  1  queue can accept; combinational = !rst && (count < DEPTH)
- if_pc  in  ADDR_W  fetched PC
- if_inst  in  INST_W  fetched instruction
- if_excepttype  in  EXC_W  exception bits from IF
- if_isbubble  in  1  IF-side bubble marker, carried through unchanged
- id_stall  in  1  1 = ID holds its current instruction (stall[2] equivalent)
- id_pc  out  ADDR_W  registered PC to ID
- id_inst  out  INST_W  registered instruction to ID
- id_excepttype  out  EXC_W  registered exception bits to ID
- id_isbubble  out  1  registered bubble flag to ID
- id_valid  out  1  id_* hold a real fetched entry
- count  out  $clog2(DEPTH+1)  queued entries, excluding the ID slot

Behaviour:
- Storage: circular buffer of DEPTH entries, each ADDR_W+INST_W+EXC_W+1 bits; rd_ptr/wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
- Push: fires when in_valid && in_ready and the entry is not bypassed.
- Reset (rst=1 at posedge): count=0, both pointers=0, id_pc/id_inst/id_excepttype=0, id_isbubble=0, id_valid=0, in_ready=0 while rst is high. Reset mid-operation discards all entries with no partial state.
- Priority per posedge: rst > flush > normal.
- Flush: count=0, pointers=0, id_pc/id_inst/id_excepttype=0, id_isbubble=1, id_valid=0. An IF push in the same cycle is discarded. id_stall is ignored.
- Normal, id_stall=1:
  - ID slot holds every field.
  - Push enqueues when in_ready.
  - count += push.
- Normal, id_stall=0, count>0:
  - ID slot loads head entry; rd_ptr++.
  - id_valid=1.
  - A simultaneous push enqueues; count unchanged when both push and pop fire.
- Normal, id_stall=0, count==0, in_valid=1:
  - Bypass: ID slot loads if_* directly, id_valid=1, no enqueue.
  - Latency IF→ID is 1 cycle, identical to the plain register.
- Normal, id_stall=0, count==0, in_valid=0: ID slot loads bubble (zeros, id_isbubble=1, id_valid=0).
- Full (count==DEPTH): in_ready=0 even if ID pops this cycle; there is no full pass-through. in_ready reasserts the cycle after count drops.
- Ordering: strict FIFO; bypass only when the queue is empty, so order is never violated.
- if_isbubble=1 entries are treated as ordinary entries: queued and presented with id_valid=1 and id_isbubble=1.

Optional Feature:
- Macro IF_ID_QUEUE_BYPASS_EN.
- Defined: empty-queue bypass as described above; minimum latency 1.
- Undefined: no bypass. Every accepted instruction is enqueued first; minimum IF→ID latency is 2 cycles. With count==0 and id_stall=0, ID loads a bubble while the incoming entry is enqueued. All other rules are unchanged.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 → id_pc=0, id_inst=0, id_isbubble=0, id_valid=0, count=0, in_ready=0; in_ready=1 on the first cycle after rst drops.
- Bypass streaming (macro on): id_stall=0, push pc 0x100,0x104,0x108 on consecutive cycles → id_pc 0x100/0x104/0x108 one cycle later each, count stays 0. Macro off → same sequence delayed 2 cycles, first ID cycle is a bubble.
- Stall fill (DEPTH=4): id_stall=1 with ID holding 0x200; push 0x204..0x214 → count reaches 4, in_ready=0, the 0x214 offer is refused and held; release stall → ID shows 0x204,0x208,0x20C,0x210 in order, then 0x214 after re-acceptance.
- Wrap-around: 10 interleaved push/pop cycles with count oscillating 1–3 → ID order equals push order across pointer wrap, no loss or duplication.
- Flush: count=3 and an in-flight push, assert flush with id_stall=1 → next cycle count=0, id_isbubble=1, id_valid=0, id_inst=0; the pushed entry never appears.
- Exception and bubble passthrough: push if_excepttype=0x0000_0200, if_isbubble=1 → same values on id_excepttype/id_isbubble with id_valid=1.
